// File: rtl/vram_dp_fill.sv
// vram_dp_fill: dual-port video RAM with a wrapping fill engine.
// Port A is the bus read/write side, port B is the pipelined scan-out read.
module vram_dp_fill #(
   parameter int unsigned          ADDR_W   = 11,
   parameter int unsigned          DATA_W   = 8,
   parameter logic [DATA_W-1:0]    FILL_VAL = 8'h20,
   parameter int unsigned          B_LAT    = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              a_valid,
   output logic              a_ready,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic [DATA_W-1:0] a_rdata,
   output logic              a_rvalid,
   input  logic [ADDR_W-1:0] b_addr,
   output logic [DATA_W-1:0] b_rdata,
   input  logic              fill_start,
   input  logic [ADDR_W-1:0] fill_base,
   input  logic [ADDR_W:0]   fill_len,
   input  logic [DATA_W-1:0] fill_data,
   output logic              fill_busy,
   output logic              fill_done
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic [DATA_W-1:0] val_q, val_d;

   logic [DATA_W-1:0] a_rdata_q;
   logic              a_rvalid_q;
   logic [DATA_W-1:0] b_q;

   // Configuration-time content; the array itself is never reset.
   logic [DATA_W-1:0] mem_q [DEPTH] = '{default: FILL_VAL};

   logic              a_xfer;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;

   assign a_ready   = (state_q != RUN);
   assign a_xfer    = a_valid & a_ready;
   assign fill_busy = (state_q == RUN);
   assign fill_done = (state_q == DONE);
   assign a_rdata   = a_rdata_q;
   assign a_rvalid  = a_rvalid_q;

   // Port A and the fill engine never write on the same edge.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = a_addr;
      mem_wdata = a_wdata;
      if (state_q == RUN) begin
         mem_we    = 1'b1;
         mem_waddr = ptr_q;
         mem_wdata = val_q;
      end else if (a_xfer && a_we) begin
         mem_we = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      val_d   = val_q;
      unique case (state_q)
         IDLE: begin
            if (fill_start) begin
               if (fill_len != '0) begin
                  state_d = RUN;
                  ptr_d   = fill_base;
                  cnt_d   = fill_len;
                  val_d   = fill_data;
               end else begin
                  state_d = DONE;
               end
            end
         end
         RUN: begin
            ptr_d = ptr_q + PTR_ONE;
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) state_d = DONE;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem_q[mem_waddr] <= mem_wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         cnt_q      <= '0;
         val_q      <= '0;
         a_rdata_q  <= '0;
         a_rvalid_q <= 1'b0;
         b_q        <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         cnt_q      <= cnt_d;
         val_q      <= val_d;
         a_rvalid_q <= a_xfer & ~a_we;
         if (a_xfer && !a_we) a_rdata_q <= mem_q[a_addr];
         b_q        <= mem_q[b_addr];
      end
   end

   generate
      if (B_LAT == 2) begin : g_lat2
         logic [DATA_W-1:0] b2_q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) b2_q <= '0;
            else        b2_q <= b_q;
         end
         assign b_rdata = b2_q;
      end else begin : g_lat1
         assign b_rdata = b_q;
      end
   endgenerate

endmodule

// File: tb/tb_vram_dp_fill.sv
// tb_vram_dp_fill: vectors, random traffic and fill sequences checked
// against an array model of the video RAM; B_LAT=1 and B_LAT=2 side by side.
module tb_vram_dp_fill;

   localparam int AW    = 11;
   localparam int DW    = 8;
   localparam int DEPTH = 2048;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          a_valid = 1'b0;
   logic          a_we = 1'b0;
   logic [AW-1:0] a_addr = '0;
   logic [DW-1:0] a_wdata = '0;
   logic [AW-1:0] b_addr = '0;
   logic          fill_start = 1'b0;
   logic [AW-1:0] fill_base = '0;
   logic [AW:0]   fill_len = '0;
   logic [DW-1:0] fill_data = '0;

   logic          a_ready1, a_rvalid1, fill_busy1, fill_done1;
   logic [DW-1:0] a_rdata1, b_rdata1;
   logic          a_ready2, a_rvalid2, fill_busy2, fill_done2;
   logic [DW-1:0] a_rdata2, b_rdata2;

   vram_dp_fill #(.ADDR_W(AW), .DATA_W(DW), .FILL_VAL(8'h20), .B_LAT(1)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a_valid), .a_ready(a_ready1), .a_we(a_we),
      .a_addr(a_addr), .a_wdata(a_wdata),
      .a_rdata(a_rdata1), .a_rvalid(a_rvalid1),
      .b_addr(b_addr), .b_rdata(b_rdata1),
      .fill_start(fill_start), .fill_base(fill_base),
      .fill_len(fill_len), .fill_data(fill_data),
      .fill_busy(fill_busy1), .fill_done(fill_done1)
   );

   vram_dp_fill #(.ADDR_W(AW), .DATA_W(DW), .FILL_VAL(8'h20), .B_LAT(2)) dut2 (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a_valid), .a_ready(a_ready2), .a_we(a_we),
      .a_addr(a_addr), .a_wdata(a_wdata),
      .a_rdata(a_rdata2), .a_rvalid(a_rvalid2),
      .b_addr(b_addr), .b_rdata(b_rdata2),
      .fill_start(fill_start), .fill_base(fill_base),
      .fill_len(fill_len), .fill_data(fill_data),
      .fill_busy(fill_busy2), .fill_done(fill_done2)
   );

   always #5 clk = ~clk;

   int n_run = 0;
   int n_fail = 0;

   logic [DW-1:0] model [DEPTH];
   logic [DW-1:0] eb1 = '0, eb2 = '0, ea = '0;
   logic          erv = 1'b0;
   int            bhist = 0;

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wd;
      logic [AW-1:0] ba;
      logic [DW-1:0] ea;
      logic [DW-1:0] eb;
   } vec_t;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] exp;
   } rd_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      bhist = 0;
   endtask

   // One idle-engine cycle: expectations come from the model before the edge.
   task automatic step();
      logic [DW-1:0] nb, na;
      logic          rv;
      nb = model[b_addr];
      na = model[a_addr];
      rv = a_valid && !a_we;
      if (a_valid && a_we) model[a_addr] = a_wdata;
      @(posedge clk);
      #1;
      eb2 = eb1;
      eb1 = nb;
      erv = rv;
      if (rv) ea = na;
      if (bhist < 2) bhist++;
      chk("a_ready", 32'(a_ready1), 32'(1));
      chk("a_rvalid", 32'(a_rvalid1), 32'(erv));
      chk("a_rvalid_l2", 32'(a_rvalid2), 32'(erv));
      if (erv) begin
         chk("a_rdata", 32'(a_rdata1), 32'(ea));
         chk("a_rdata_l2", 32'(a_rdata2), 32'(ea));
      end
      if (bhist >= 1) chk("b_rdata_l1", 32'(b_rdata1), 32'(eb1));
      if (bhist >= 2) chk("b_rdata_l2", 32'(b_rdata2), 32'(eb2));
   endtask

   task automatic sweep(input int lo, input int n);
      a_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
         b_addr = AW'((lo + i) % DEPTH);
         step();
      end
      step();
      step();
   endtask

   task automatic do_fill(input logic [AW-1:0] base, input logic [AW:0] len,
                          input logic [DW-1:0] d, input int poke, input logic hold,
                          input string nm);
      fill_start = 1'b1;
      fill_base  = base;
      fill_len   = len;
      fill_data  = d;
      tick();
      fill_start = 1'b0;
      a_valid    = hold;
      for (int i = 0; i < int'(len); i++) begin
         chk({nm, "_busy"}, 32'(fill_busy1), 32'(1));
         chk({nm, "_busy_l2"}, 32'(fill_busy2), 32'(1));
         chk({nm, "_done_early"}, 32'(fill_done1), 32'(0));
         chk({nm, "_ready_low"}, 32'(a_ready1), 32'(0));
         if (i == poke) begin
            fill_start = 1'b1;
            fill_base  = base + AW'(16);
            fill_len   = (AW+1)'(8);
            fill_data  = ~d;
         end
         tick();
         fill_start = 1'b0;
      end
      chk({nm, "_busy_end"}, 32'(fill_busy1), 32'(0));
      chk({nm, "_done"}, 32'(fill_done1), 32'(1));
      chk({nm, "_done_l2"}, 32'(fill_done2), 32'(1));
      chk({nm, "_ready_end"}, 32'(a_ready1), 32'(1));
      tick();
      a_valid = 1'b0;
      chk({nm, "_done_pulse"}, 32'(fill_done1), 32'(0));
      chk({nm, "_busy_after"}, 32'(fill_busy1), 32'(0));
      for (int i = 0; i < int'(len); i++) model[(int'(base) + i) % DEPTH] = d;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t vec [8];
      rd_t  wr [8];

      for (int i = 0; i < DEPTH; i++) model[i] = 8'h20;

      vec[0] = '{1'b0, 11'h000, 8'h00, 11'h000, 8'h20, 8'h20};
      vec[1] = '{1'b0, 11'h3FF, 8'h00, 11'h3FF, 8'h20, 8'h20};
      vec[2] = '{1'b0, 11'h7FF, 8'h00, 11'h7FF, 8'h20, 8'h20};
      vec[3] = '{1'b1, 11'h005, 8'h41, 11'h005, 8'h00, 8'h20};
      vec[4] = '{1'b0, 11'h005, 8'h00, 11'h005, 8'h41, 8'h41};
      vec[5] = '{1'b1, 11'h005, 8'h55, 11'h005, 8'h00, 8'h41};
      vec[6] = '{1'b0, 11'h005, 8'h00, 11'h006, 8'h55, 8'h20};
      vec[7] = '{1'b0, 11'h005, 8'h00, 11'h005, 8'h55, 8'h55};

      wr[0] = '{11'h7FD, 8'h2A};
      wr[1] = '{11'h7FE, 8'h00};
      wr[2] = '{11'h7FF, 8'h00};
      wr[3] = '{11'h000, 8'h00};
      wr[4] = '{11'h001, 8'h00};
      wr[5] = '{11'h002, 8'h2A};
      wr[6] = '{11'h300, 8'h5A};
      wr[7] = '{11'h00E, 8'h2A};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_a_rvalid", 32'(a_rvalid1), 32'(0));
      chk("rst_a_rdata", 32'(a_rdata1), 32'(0));
      chk("rst_b_rdata", 32'(b_rdata1), 32'(0));
      chk("rst_b_rdata_l2", 32'(b_rdata2), 32'(0));
      chk("rst_busy", 32'(fill_busy1 | fill_busy2), 32'(0));
      chk("rst_done", 32'(fill_done1 | fill_done2), 32'(0));
      chk("rst_ready", 32'(a_ready1 & a_ready2), 32'(1));
      rst_n = 1'b1;

      // Power-up reads, write/read and same-address collisions
      for (int i = 0; i < 8; i++) begin
         a_valid = 1'b1;
         a_we    = vec[i].we;
         a_addr  = vec[i].addr;
         a_wdata = vec[i].wd;
         b_addr  = vec[i].ba;
         step();
         if (!vec[i].we) chk("vec_a_rdata", 32'(a_rdata1), 32'(vec[i].ea));
         chk("vec_b_rdata", 32'(b_rdata1), 32'(vec[i].eb));
      end
      a_valid = 1'b0;
      step();
      step();

      // Random port A / port B traffic on a small window
      for (int i = 0; i < 400; i++) begin
         a_valid = ($urandom_range(3) != 0);
         a_we    = $urandom_range(1) == 1;
         a_addr  = AW'($urandom_range(31));
         a_wdata = DW'($urandom);
         b_addr  = AW'($urandom_range(31));
         step();
      end
      a_valid = 1'b0;
      step();

      // Full clear with a write held across the busy window
      a_we    = 1'b1;
      a_addr  = 11'h100;
      a_wdata = 8'h77;
      do_fill(11'h000, 12'd2048, 8'h2A, -1, 1'b1, "full");
      model[11'h100] = 8'h77;
      sweep(0, DEPTH);
      a_valid = 1'b1;
      a_we    = 1'b0;
      a_addr  = 11'h100;
      step();
      chk("held_write", 32'(a_rdata1), 32'(8'h77));
      a_addr  = 11'h0FF;
      step();
      chk("full_0ff", 32'(a_rdata1), 32'(8'h2A));
      a_valid = 1'b0;

      // Wrapping fill; port A write in the start cycle; start while busy ignored
      a_valid = 1'b1;
      a_we    = 1'b1;
      a_addr  = 11'h300;
      a_wdata = 8'h5A;
      model[11'h300] = 8'h5A;
      do_fill(11'h7FE, 12'd4, 8'h00, 1, 1'b0, "wrap");
      for (int i = 0; i < 8; i++) begin
         a_valid = 1'b1;
         a_we    = 1'b0;
         a_addr  = wr[i].addr;
         step();
         chk("wrap_rd", 32'(a_rdata1), 32'(wr[i].exp));
      end
      a_valid = 1'b0;
      sweep(DEPTH - 8, 32);

      // Zero-length fill
      do_fill(11'h050, 12'd0, 8'h11, -1, 1'b0, "zero");
      sweep(11'h04C, 9);

      // Reset in the middle of a 64-byte fill
      fill_start = 1'b1;
      fill_base  = 11'h200;
      fill_len   = 12'd64;
      fill_data  = 8'hC3;
      tick();
      fill_start = 1'b0;
      repeat (10) tick();
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(fill_busy1), 32'(0));
      chk("mid_rst_busy_l2", 32'(fill_busy2), 32'(0));
      chk("mid_rst_done", 32'(fill_done1), 32'(0));
      chk("mid_rst_b", 32'(b_rdata1 | b_rdata2), 32'(0));
      chk("mid_rst_rdata", 32'(a_rdata1), 32'(0));
      tick();
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) model[11'h200 + i] = 8'hC3;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("post_rst_done", 32'(fill_done1), 32'(0));
         chk("post_rst_busy", 32'(fill_busy1), 32'(0));
      end
      sweep(11'h1F8, 80);
      a_valid = 1'b1;
      a_we    = 1'b0;
      a_addr  = 11'h209;
      step();
      chk("mid_last_filled", 32'(a_rdata1), 32'(8'hC3));
      a_addr  = 11'h20A;
      step();
      chk("mid_first_kept", 32'(a_rdata1), 32'(8'h2A));
      a_valid = 1'b0;
      step();

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
